// File: rtl/shared_cell_arbiter_pkg.sv
// Shared definitions for the shared_cell_arbiter block: FSM state encoding
// and default sizing.
package shared_cell_arbiter_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 6;
  localparam int IDW_DEF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/shared_cell_arbiter_cells.sv
// Leaf cells of the arbiter: the round-robin picker and the 1-bit select
// cell that forms the shared datapath.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IDW-1:0]  last,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  logic [NREQ-1:0]   eff_s;
  logic [2*NREQ-1:0] dbl_s;
  logic [2*NREQ-1:0] rot_full_s;
  logic [NREQ-1:0]   rot_s;
  int                off_s;
  int                sum_s;

  // Rotate so bit 0 is the slot after last, then take the lowest set bit.
  always_comb begin
    eff_s      = req & ~mask;
    dbl_s      = {eff_s, eff_s};
    rot_full_s = dbl_s >> (int'(last) + 32'sd1);
    rot_s      = rot_full_s[NREQ-1:0];
    found      = 1'b0;
    off_s      = 32'sd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        found = 1'b1;
        off_s = k;
      end else begin
        off_s = off_s;
      end
    end
    sum_s = int'(last) + 32'sd1 + off_s;
    if (sum_s >= NREQ) begin
      sum_s = sum_s - NREQ;
    end else begin
      sum_s = sum_s;
    end
    idx = IDW'(sum_s);
  end

endmodule

module sel_cell (
  input  logic a,
  input  logic b,
  output logic z
);

  assign z = a ? a : b;

endmodule

// File: rtl/shared_cell_arbiter.sv
// Round-robin arbiter sharing one bitwise select datapath among NREQ
// requesters: grant, operand capture, tagged response.
module shared_cell_arbiter
  import shared_cell_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_flat,
  input  logic [NREQ*W-1:0] b_flat,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              busy
);

  state_t          state_r;
  logic [IDW-1:0]  cur_id_r;
  logic [IDW-1:0]  last_r;
  logic [NREQ-1:0] gnt_r;
  logic            rsp_valid_r;
  logic [IDW-1:0]  rsp_id_r;
  logic [W-1:0]    op_a_r;
  logic [W-1:0]    op_b_r;
  logic            busy_r;

  logic [NREQ-1:0] pick_mask_s;
  logic [IDW-1:0]  pick_last_s;
  logic            pick_found_s;
  logic [IDW-1:0]  pick_idx_s;
  logic [W-1:0]    a_sel_s;
  logic [W-1:0]    b_sel_s;
  logic [W-1:0]    res_s;

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
    logic [NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = (id == IDW'(i));
    end
    return v;
  endfunction

  // In RESP the picker must already see the updated last and skip the
  // requester just served, whose req may still be high for this cycle.
  always_comb begin
    if (state_r == ST_RESP) begin
      pick_last_s = cur_id_r;
      pick_mask_s = onehot(cur_id_r);
    end else begin
      pick_last_s = last_r;
      pick_mask_s = '0;
    end
  end

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req   (req),
    .mask  (pick_mask_s),
    .last  (pick_last_s),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Operand mux for the requester currently holding the grant.
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (cur_id_r == IDW'(i)) begin
        a_sel_s = a_flat[i*W +: W];
        b_sel_s = b_flat[i*W +: W];
      end else begin
        a_sel_s = a_sel_s;
        b_sel_s = b_sel_s;
      end
    end
  end

  // Arbitration FSM; every output is a register loaded on state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cur_id_r    <= '0;
      last_r      <= IDW'(NREQ - 1);
      gnt_r       <= '0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rsp_valid_r <= 1'b0;
          if (en && pick_found_s) begin
            state_r  <= ST_ISSUE;
            cur_id_r <= pick_idx_s;
            gnt_r    <= onehot(pick_idx_s);
            busy_r   <= 1'b1;
          end else begin
            gnt_r  <= '0;
            busy_r <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // Operands are taken here even if the requester dropped req early.
          gnt_r       <= '0;
          op_a_r      <= a_sel_s;
          op_b_r      <= b_sel_s;
          rsp_valid_r <= 1'b1;
          rsp_id_r    <= cur_id_r;
          busy_r      <= 1'b1;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid_r <= 1'b0;
          last_r      <= cur_id_r;
          if (en && pick_found_s) begin
            state_r  <= ST_ISSUE;
            cur_id_r <= pick_idx_s;
            gnt_r    <= onehot(pick_idx_s);
            busy_r   <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            gnt_r   <= '0;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          gnt_r       <= '0;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < W; g++) begin : g_cell
    sel_cell u_cell (
      .a (op_a_r[g]),
      .b (op_b_r[g]),
      .z (res_s[g])
    );
  end

  assign gnt       = gnt_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = res_s;
  assign busy      = busy_r;

endmodule

// File: tb/tb_shared_cell_arbiter.sv
// Directed bench for shared_cell_arbiter: per-cycle vector table plus
// hand-written sequences for en gating, mid-operation reset and capture timing.
module tb_shared_cell_arbiter;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [23:0] a_flat;
  logic [23:0] b_flat;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [5:0]  rsp_data;
  logic        busy;

  int checks;
  int failures;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       rv;
    logic [1:0] id;
    logic [5:0] data;
    logic       busy;
  } vec_t;

  vec_t tbl [18];

  shared_cell_arbiter #(.NREQ(4), .W(6), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    en       = 1'b0;
    req      = 4'b0000;
    // results per requester: r0=21 r1=06 r2=27 r3=18
    a_flat   = {6'h10, 6'h05, 6'h02, 6'h01};
    b_flat   = {6'h08, 6'h22, 6'h04, 6'h20};

    //            rst   en    req      gnt      rv    id     data   busy
    tbl[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 6'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0, 2'd0, 6'h00, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd2, 6'h27, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, 6'h27, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 6'h00, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0, 2'd0, 6'h00, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 4'b1110, 4'b0000, 1'b1, 2'd0, 6'h21, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 4'b1110, 4'b0010, 1'b0, 2'd0, 6'h21, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 4'b1100, 4'b0000, 1'b1, 2'd1, 6'h06, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 4'b1100, 4'b0100, 1'b0, 2'd1, 6'h06, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 4'b1000, 4'b0000, 1'b1, 2'd2, 6'h27, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 4'b1000, 4'b1000, 1'b0, 2'd2, 6'h27, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 4'b1001, 4'b0000, 1'b1, 2'd3, 6'h18, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 4'b1001, 4'b0001, 1'b0, 2'd3, 6'h18, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 4'b1000, 4'b0000, 1'b1, 2'd0, 6'h21, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 4'b1000, 4'b1000, 1'b0, 2'd0, 6'h21, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd3, 6'h18, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd3, 6'h18, 1'b0};

    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst;
      en  = tbl[i].en;
      req = tbl[i].req;
      step();
      chk($sformatf("v%0d_gnt", i),  {28'd0, gnt},       {28'd0, tbl[i].gnt});
      chk($sformatf("v%0d_rv", i),   {31'd0, rsp_valid}, {31'd0, tbl[i].rv});
      chk($sformatf("v%0d_id", i),   {30'd0, rsp_id},    {30'd0, tbl[i].id});
      chk($sformatf("v%0d_data", i), {26'd0, rsp_data},  {26'd0, tbl[i].data});
      chk($sformatf("v%0d_busy", i), {31'd0, busy},      {31'd0, tbl[i].busy});
    end

    // en gating: nothing leaves IDLE while en is low
    en  = 1'b0;
    req = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("engate%0d_gnt", c),  {28'd0, gnt},  32'd0);
      chk($sformatf("engate%0d_busy", c), {31'd0, busy}, 32'd0);
    end
    en = 1'b1;
    step();
    chk("engate_release_gnt", {28'd0, gnt}, 32'h2);
    // en low during ISSUE must not abort the transaction
    en  = 1'b0;
    req = 4'b0000;
    step();
    chk("engate_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("engate_rsp_id",    {30'd0, rsp_id},    32'd1);
    chk("engate_rsp_data",  {26'd0, rsp_data},  32'h06);
    step();
    chk("engate_idle_busy", {31'd0, busy}, 32'd0);

    // reset during ISSUE drops the transaction
    en  = 1'b1;
    req = 4'b0100;
    step();
    chk("midrst_issue_gnt", {28'd0, gnt}, 32'h4);
    rst = 1'b1;
    #1;
    chk("midrst_gnt",  {28'd0, gnt},       32'd0);
    chk("midrst_rv",   {31'd0, rsp_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy},      32'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("midrst_norsp%0d", c), {31'd0, rsp_valid}, 32'd0);
    end
    req = 4'b0101;
    step();
    chk("midrst_first_gnt", {28'd0, gnt}, 32'h1);
    req = 4'b0000;
    step();
    chk("midrst_rsp_id", {30'd0, rsp_id}, 32'd0);
    step();

    // operand change right after ISSUE must not reach the result
    a_flat[11:6] = 6'h3F;
    b_flat[11:6] = 6'h04;
    req = 4'b0010;
    step();
    chk("cap_gnt", {28'd0, gnt}, 32'h2);
    @(posedge clk);
    #1;
    a_flat[11:6] = 6'h00;
    req = 4'b0000;
    @(negedge clk);
    chk("cap_rv",   {31'd0, rsp_valid}, 32'd1);
    chk("cap_id",   {30'd0, rsp_id},    32'd1);
    chk("cap_data", {26'd0, rsp_data},  32'h3F);
    step();
    chk("cap_hold_data", {26'd0, rsp_data},  32'h3F);
    chk("cap_hold_rv",   {31'd0, rsp_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
